// File: rtl/matrix_seq_pkg.sv
// matrix_seq_pkg: shared types and tile address helpers
// for the matrix tile sequencer.
package matrix_seq_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MAC,
    WRITE,
    DONE
  } state_t;

  function automatic int unsigned addr_width(
    input int unsigned height
  );
    return $clog2(height >> 1) + 1;
  endfunction

  // Word address of the upper (or lower) row of tile (r,c).
  function automatic int unsigned tile_addr(
    input int unsigned base,
    input int unsigned r,
    input int unsigned c,
    input int unsigned n,
    input int unsigned lower_row
  );
    return base + (2 * r + lower_row) * n + 2 * c;
  endfunction

endpackage

// File: rtl/tile_mac2x2.sv
// tile_mac2x2: 2x2 by 2x2 product added to a 2x2 accumulator,
// all arithmetic modulo 2^32.
module tile_mac2x2
  import matrix_seq_pkg::*;
(
  input  word_t a00,
  input  word_t a01,
  input  word_t a10,
  input  word_t a11,
  input  word_t b00,
  input  word_t b01,
  input  word_t b10,
  input  word_t b11,
  input  word_t acc00,
  input  word_t acc01,
  input  word_t acc10,
  input  word_t acc11,
  output word_t sum00,
  output word_t sum01,
  output word_t sum10,
  output word_t sum11
);

  assign sum00 = acc00 + a00 * b00 + a01 * b10;
  assign sum01 = acc01 + a00 * b01 + a01 * b11;
  assign sum10 = acc10 + a10 * b00 + a11 * b10;
  assign sum11 = acc11 + a10 * b01 + a11 * b11;

endmodule

// File: rtl/matrix_tile_sequencer.sv
// matrix_tile_sequencer: tiled 2x2 matrix multiply initiator.
// Define MATSEQ_CYCLE_COUNT_EN to add the cycle_count output.
module matrix_tile_sequencer
  import matrix_seq_pkg::*;
#(
  parameter int unsigned MEMORY_HEIGHT = 4000,
  parameter int unsigned MATRIX_DIM = 4,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 16,
  parameter int unsigned C_BASE = 32,
  localparam int unsigned AW = addr_width(MEMORY_HEIGHT)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] address_one_row1_2,
  output logic [AW-1:0] address_one_row3_4,
  output logic [AW-1:0] address_two_row1_2,
  output logic [AW-1:0] address_two_row3_4,
  input  logic [31:0]   matrix_one_00,
  input  logic [31:0]   matrix_one_01,
  input  logic [31:0]   matrix_one_10,
  input  logic [31:0]   matrix_one_11,
  input  logic [31:0]   matrix_two_00,
  input  logic [31:0]   matrix_two_01,
  input  logic [31:0]   matrix_two_10,
  input  logic [31:0]   matrix_two_11,
  output logic          write_enable_1_2,
  output logic          write_enable_3_4,
  output logic [AW-1:0] write_add_row1_2,
  output logic [AW-1:0] write_add_row3_4,
  output logic [31:0]   write_data_00,
  output logic [31:0]   write_data_01,
  output logic [31:0]   write_data_10,
`ifdef MATSEQ_CYCLE_COUNT_EN
  output logic [31:0]   write_data_11,
  output logic [31:0]   cycle_count
`else
  output logic [31:0]   write_data_11
`endif
);

  localparam int unsigned T = MATRIX_DIM / 2;
  localparam int unsigned IW = (T > 1) ? $clog2(T) : 1;
  localparam logic [IW-1:0] LAST = IW'(T - 1);

  if (MATRIX_DIM % 2 != 0 || MATRIX_DIM < 2) begin : g_dim_check
    $error("MATRIX_DIM must be even and at least 2");
  end

  state_t          state;
  logic [IW-1:0]   ti, tj, tk;
  logic [IW-1:0]   fi, fj, fk;
  logic            go_fetch;
  word_t [3:0]     acc;
  word_t [3:0]     sum;
  logic [AW-1:0]   a_hi, a_lo, b_hi, b_lo, c_hi, c_lo;

  // Indices of the tile step the next FETCH will present.
  always_comb begin
    fi = ti;
    fj = tj;
    fk = '0;
    go_fetch = 1'b0;
    unique case (state)
      IDLE: begin
        fi = '0;
        fj = '0;
        go_fetch = start;
      end
      MAC: begin
        fk = tk + 1'b1;
        go_fetch = (tk != LAST);
      end
      WRITE: begin
        go_fetch = !(ti == LAST && tj == LAST);
        if (tj == LAST) begin
          fi = ti + 1'b1;
          fj = '0;
        end else begin
          fj = tj + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign a_hi = AW'(tile_addr(A_BASE, 32'(fi), 32'(fk), MATRIX_DIM, 0));
  assign a_lo = AW'(tile_addr(A_BASE, 32'(fi), 32'(fk), MATRIX_DIM, 1));
  assign b_hi = AW'(tile_addr(B_BASE, 32'(fk), 32'(fj), MATRIX_DIM, 0));
  assign b_lo = AW'(tile_addr(B_BASE, 32'(fk), 32'(fj), MATRIX_DIM, 1));
  assign c_hi = AW'(tile_addr(C_BASE, 32'(ti), 32'(tj), MATRIX_DIM, 0));
  assign c_lo = AW'(tile_addr(C_BASE, 32'(ti), 32'(tj), MATRIX_DIM, 1));

  tile_mac2x2 u_mac (
    .a00   (matrix_one_00),
    .a01   (matrix_one_01),
    .a10   (matrix_one_10),
    .a11   (matrix_one_11),
    .b00   (matrix_two_00),
    .b01   (matrix_two_01),
    .b10   (matrix_two_10),
    .b11   (matrix_two_11),
    .acc00 (acc[0]),
    .acc01 (acc[1]),
    .acc10 (acc[2]),
    .acc11 (acc[3]),
    .sum00 (sum[0]),
    .sum01 (sum[1]),
    .sum10 (sum[2]),
    .sum11 (sum[3])
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      ti <= '0;
      tj <= '0;
      tk <= '0;
      acc <= '0;
      address_one_row1_2 <= '0;
      address_one_row3_4 <= '0;
      address_two_row1_2 <= '0;
      address_two_row3_4 <= '0;
      write_enable_1_2 <= 1'b0;
      write_enable_3_4 <= 1'b0;
      write_add_row1_2 <= '0;
      write_add_row3_4 <= '0;
      write_data_00 <= '0;
      write_data_01 <= '0;
      write_data_10 <= '0;
      write_data_11 <= '0;
    end else begin
      done <= 1'b0;
      write_enable_1_2 <= 1'b0;
      write_enable_3_4 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            acc <= '0;
          end
        end
        FETCH: state <= MAC;
        MAC: begin
          acc <= sum;
          if (tk == LAST) begin
            state <= WRITE;
            write_enable_1_2 <= 1'b1;
            write_enable_3_4 <= 1'b1;
            write_add_row1_2 <= c_hi;
            write_add_row3_4 <= c_lo;
            address_two_row3_4 <= c_lo;
            write_data_00 <= sum[0];
            write_data_01 <= sum[1];
            write_data_10 <= sum[2];
            write_data_11 <= sum[3];
          end
        end
        WRITE: begin
          acc <= '0;
          if (!go_fetch) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_fetch) begin
        state <= FETCH;
        ti <= fi;
        tj <= fj;
        tk <= fk;
        address_one_row1_2 <= a_hi;
        address_one_row3_4 <= a_lo;
        address_two_row1_2 <= b_hi;
        address_two_row3_4 <= b_lo;
      end
    end
  end

`ifdef MATSEQ_CYCLE_COUNT_EN
  // Counts every cycle from acceptance through the done cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if (state == IDLE) begin
      if (start) cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_tile_sequencer.sv
// tb_matrix_tile_sequencer: directed checks of N=2 and N=4
// sequencers against a behavioural tile memory.
module tb_matrix_tile_sequencer;

  localparam int AW = 12;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic          start_a [2];
  logic          busy_a  [2];
  logic          done_a  [2];
  logic          we12_a  [2];
  logic          we34_a  [2];
  logic [AW-1:0] ao12_a  [2];
  logic [AW-1:0] ao34_a  [2];
  logic [AW-1:0] bo12_a  [2];
  logic [AW-1:0] bo34_a  [2];
  logic [AW-1:0] wa12_a  [2];
  logic [AW-1:0] wa34_a  [2];
  logic [31:0]   wd_a    [2][4];
  logic [31:0]   cc_a    [2];

  logic        ld_en;
  int          ld_sel;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  int checks;
  int failures;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [31:0] mem [64];
    logic [31:0] ra [4];
    logic [31:0] rb [4];

    matrix_tile_sequencer #(
      .MATRIX_DIM (d == 1 ? 4 : 2)
    ) u_dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .start              (start_a[d]),
      .busy               (busy_a[d]),
      .done               (done_a[d]),
      .address_one_row1_2 (ao12_a[d]),
      .address_one_row3_4 (ao34_a[d]),
      .address_two_row1_2 (bo12_a[d]),
      .address_two_row3_4 (bo34_a[d]),
      .matrix_one_00      (ra[0]),
      .matrix_one_01      (ra[1]),
      .matrix_one_10      (ra[2]),
      .matrix_one_11      (ra[3]),
      .matrix_two_00      (rb[0]),
      .matrix_two_01      (rb[1]),
      .matrix_two_10      (rb[2]),
      .matrix_two_11      (rb[3]),
      .write_enable_1_2   (we12_a[d]),
      .write_enable_3_4   (we34_a[d]),
      .write_add_row1_2   (wa12_a[d]),
      .write_add_row3_4   (wa34_a[d]),
      .write_data_00      (wd_a[d][0]),
      .write_data_01      (wd_a[d][1]),
      .write_data_10      (wd_a[d][2]),
`ifdef MATSEQ_CYCLE_COUNT_EN
      .write_data_11      (wd_a[d][3]),
      .cycle_count        (cc_a[d])
`else
      .write_data_11      (wd_a[d][3])
`endif
    );

    always @(posedge clock) begin
      ra[0] <= mem[ao12_a[d][5:0]];
      ra[1] <= mem[6'(ao12_a[d][5:0] + 6'd1)];
      ra[2] <= mem[ao34_a[d][5:0]];
      ra[3] <= mem[6'(ao34_a[d][5:0] + 6'd1)];
      rb[0] <= mem[bo12_a[d][5:0]];
      rb[1] <= mem[6'(bo12_a[d][5:0] + 6'd1)];
      rb[2] <= mem[bo34_a[d][5:0]];
      rb[3] <= mem[6'(bo34_a[d][5:0] + 6'd1)];
      if (we12_a[d]) begin
        mem[wa12_a[d][5:0]] <= wd_a[d][0];
        mem[6'(wa12_a[d][5:0] + 6'd1)] <= wd_a[d][1];
      end
      if (we34_a[d]) begin
        mem[wa34_a[d][5:0]] <= wd_a[d][2];
        mem[6'(wa34_a[d][5:0] + 6'd1)] <= wd_a[d][3];
      end
      if (ld_en && ld_sel == d) mem[ld_addr] <= ld_data;
    end
  end

`ifndef MATSEQ_CYCLE_COUNT_EN
  assign cc_a[0] = '0;
  assign cc_a[1] = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdmem(input int sel, input int a);
    return (sel == 1) ? g_dut[1].mem[a] : g_dut[0].mem[a];
  endfunction

  task automatic put(input int sel, input int addr, input logic [31:0] v);
    ld_en = 1'b1;
    ld_sel = sel;
    ld_addr = 6'(addr);
    ld_data = v;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic load(input int sel, input int n,
                      input logic [31:0] a [16], input logic [31:0] b [16]);
    for (int i = 0; i < n * n; i++) begin
      put(sel, i, a[i]);
      put(sel, 16 + i, b[i]);
      put(sel, 32 + i, 32'hDEADBEEF);
    end
  endtask

  task automatic chk_c(input int sel, input int n, input logic [31:0] exp [16]);
    for (int i = 0; i < n * n; i++)
      chk($sformatf("c%0d_n%0d", i, n), 64'(rdmem(sel, 32 + i)), 64'(exp[i]));
  endtask

  // Called at a negedge; the following posedge is cycle 1.
  task automatic run(input int sel, input int n, input bit glitch);
    int t, lat, dones, wr, ti, tj;
    t = n / 2;
    lat = 0;
    dones = 0;
    wr = 0;
    start_a[sel] = 1'b1;
    @(negedge clock);
    start_a[sel] = 1'b0;
    chk("busy_on", 64'(busy_a[sel]), 64'd1);
    chk("fetch_a", 64'({ao12_a[sel], ao34_a[sel]}), 64'({12'd0, 12'(n)}));
    chk("fetch_b", 64'({bo12_a[sel], bo34_a[sel]}),
        64'({12'd16, 12'(16 + n)}));
    for (int k = 2; k <= 120; k++) begin
      start_a[sel] = glitch && (k == 3 || k == 10);
      @(negedge clock);
      if (we12_a[sel] || we34_a[sel]) begin
        ti = wr / t;
        tj = wr % t;
        chk("we_pair", 64'({we12_a[sel], we34_a[sel]}), 64'd3);
        chk("wr_addr", 64'({wa12_a[sel], wa34_a[sel]}),
            64'({12'(32 + 2 * ti * n + 2 * tj),
                 12'(32 + (2 * ti + 1) * n + 2 * tj)}));
        chk("b34_wr", 64'(bo34_a[sel]),
            64'(12'(32 + (2 * ti + 1) * n + 2 * tj)));
        wr++;
      end
      if (done_a[sel]) begin
        dones++;
        if (lat == 0) begin
          lat = k;
          chk("busy_off", 64'(busy_a[sel]), 64'd0);
        end
      end
      if (lat != 0 && k >= lat + 4) break;
    end
    start_a[sel] = 1'b0;
    chk("latency", 64'(lat), 64'(t * t * (2 * t + 1) + 1));
    chk("done_cnt", 64'(dones), 64'd1);
    chk("writes", 64'(wr), 64'(t * t));
  endtask

  initial begin
    logic [31:0] va [16];
    logic [31:0] vb [16];
    logic [31:0] vc [16];
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    start_a[0] = 1'b0;
    start_a[1] = 1'b0;
    ld_en = 1'b0;
    ld_sel = 0;
    ld_addr = '0;
    ld_data = '0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctl", 64'({busy_a[d], done_a[d], we12_a[d], we34_a[d]}), 64'd0);
      chk("rst_raddr", 64'({ao12_a[d], ao34_a[d], bo12_a[d], bo34_a[d]}), 64'd0);
      chk("rst_waddr", 64'({wa12_a[d], wa34_a[d]}), 64'd0);
      chk("rst_wdata", 64'(wd_a[d][0] | wd_a[d][1] | wd_a[d][2] | wd_a[d][3]),
          64'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);

    // N=2 basic product
    for (int i = 0; i < 16; i++) begin va[i] = 0; vb[i] = 0; vc[i] = 0; end
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
    vc[0] = 19; vc[1] = 22; vc[2] = 43; vc[3] = 50;
    load(0, 2, va, vb);
    run(0, 2, 1'b0);
    chk_c(0, 2, vc);
`ifdef MATSEQ_CYCLE_COUNT_EN
    chk("cycles_n2", 64'(cc_a[0]), 64'd4);
`endif

    // N=4 all ones by all twos
    for (int i = 0; i < 16; i++) begin va[i] = 1; vb[i] = 2; vc[i] = 8; end
    load(1, 4, va, vb);
    run(1, 4, 1'b0);
    chk_c(1, 4, vc);

    // N=4 identity times 0..15
    for (int i = 0; i < 16; i++) begin
      va[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
      vb[i] = 32'(i);
      vc[i] = 32'(i);
    end
    load(1, 4, va, vb);
    run(1, 4, 1'b0);
    chk_c(1, 4, vc);

    // N=2 modulo 2^32 wrap
    for (int i = 0; i < 16; i++) begin va[i] = 0; vb[i] = 0; vc[i] = 0; end
    va[0] = 32'h0001_0000;
    vb[0] = 32'h0001_0000;
    load(0, 2, va, vb);
    run(0, 2, 1'b0);
    chk_c(0, 2, vc);

    // N=4 with start re-pulsed while busy
    for (int i = 0; i < 16; i++) begin
      va[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
      vb[i] = 32'(i + 100);
      vc[i] = 32'(i + 100);
    end
    load(1, 4, va, vb);
    run(1, 4, 1'b1);
    chk_c(1, 4, vc);

    // N=4 aborted by reset at cycle 7, then a clean run
    for (int i = 0; i < 16; i++) begin va[i] = 1; vb[i] = 2; vc[i] = 8; end
    load(1, 4, va, vb);
    start_a[1] = 1'b1;
    @(negedge clock);
    start_a[1] = 1'b0;
    repeat (6) @(negedge clock);
    chk("mid_busy", 64'(busy_a[1]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ctl", 64'({busy_a[1], done_a[1], we12_a[1], we34_a[1]}), 64'd0);
    chk("arst_raddr", 64'({ao12_a[1], ao34_a[1], bo12_a[1], bo34_a[1]}), 64'd0);
    chk("arst_wdata", 64'(wd_a[1][0] | wd_a[1][1] | wd_a[1][2] | wd_a[1][3]),
        64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    load(1, 4, va, vb);
    run(1, 4, 1'b0);
    chk_c(1, 4, vc);
`ifdef MATSEQ_CYCLE_COUNT_EN
    chk("cycles_n4", 64'(cc_a[1]), 64'd21);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
